// File: rtl/spi_reg_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_update_scheduler
//  Brief    : Buffers decoded SPI write frames in a small FIFO, applies them
//             to shadow registers, and commits dirty shadow values to the
//             active outputs only at PWM period boundaries (or on request).
//             Registers flagged in IMMEDIATE_MASK bypass the boundary wait.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_update_scheduler #(
    parameter int                  NUM_REGS       = 5,
    parameter int                  FIFO_DEPTH     = 4,
    parameter logic [NUM_REGS-1:0] IMMEDIATE_MASK = 5'b00011
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [6:0]              wr_addr,
    input  logic [7:0]              wr_data,
    output logic                    wr_ready,
    input  logic                    period_start,
    input  logic                    force_commit,
    input  logic                    hold,
    output logic [8*NUM_REGS-1:0]   regs_active,
    output logic                    pending,
    output logic                    commit_done,
    output logic [7:0]              drop_count
);

    // Register-index width stored in the FIFO; at least one bit.
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // FIFO pointer width; pointers wrap naturally since depth is a power of 2.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AW + 8;

    localparam logic [6:0]  NUM_REGS_A = 7'(NUM_REGS);
    localparam logic [PW:0] DEPTH_C    = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [FIFO_DEPTH-1:0][EW-1:0] fifo_q, fifo_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [PW:0]                   count_q, count_d;
    logic [NUM_REGS-1:0][7:0]      shadow_q, shadow_d;
    logic [NUM_REGS-1:0][7:0]      active_q, active_d;
    logic [NUM_REGS-1:0]           dirty_q, dirty_d;
    logic                          commit_done_q, commit_done_d;
    logic [7:0]                    drop_count_q, drop_count_d;

    logic          w_full;
    logic          w_accept;
    logic          w_addr_ok;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;
    logic [AW-1:0] w_pop_addr;
    logic [7:0]    w_pop_data;
    logic          w_commit;
    logic          w_pop_set_dirty;

    assign w_full     = (count_q == DEPTH_C);
    assign wr_ready   = !w_full;
    assign w_accept   = wr_valid && wr_ready;
    assign w_addr_ok  = (wr_addr < NUM_REGS_A);
    assign w_push     = w_accept && w_addr_ok;
    assign w_pop      = (count_q != '0);
    assign w_head     = fifo_q[rd_ptr_q];
    assign w_pop_addr = w_head[EW-1:8];
    assign w_pop_data = w_head[7:0];
    assign w_commit   = (state_q == ST_COMMIT);

    assign regs_active = active_q;
    assign pending     = |dirty_q;
    assign commit_done = commit_done_q;
    assign drop_count  = drop_count_q;

    // FIFO push/pop bookkeeping and the saturating invalid-address counter.
    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_count_d = drop_count_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = {wr_addr[AW-1:0], wr_data};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_accept && !w_addr_ok && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Shadow/active/dirty update: the commit uses pre-pop shadow values, and a
    // pop landing in the commit cycle re-marks its register dirty (set wins).
    always_comb begin
        shadow_d        = shadow_q;
        active_d        = active_q;
        dirty_d         = dirty_q;
        w_pop_set_dirty = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_commit && dirty_q[i]) begin
                active_d[i] = shadow_q[i];
                dirty_d[i]  = 1'b0;
            end
            if (w_pop && (w_pop_addr == AW'(i))) begin
                shadow_d[i] = w_pop_data;
                if (IMMEDIATE_MASK[i]) begin
                    active_d[i] = w_pop_data;
                end else begin
                    dirty_d[i]      = 1'b1;
                    w_pop_set_dirty = 1'b1;
                end
            end
        end
    end

    // Commit scheduler next-state logic; hold drops boundary requests entirely.
    always_comb begin
        state_d       = state_q;
        commit_done_d = w_commit;
        case (state_q)
            ST_IDLE: begin
                if (|dirty_q) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if ((period_start || force_commit) && !hold) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = w_pop_set_dirty ? ST_PENDING : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            dirty_q       <= '0;
            commit_done_q <= 1'b0;
            drop_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
            drop_count_q  <= drop_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_update_scheduler
//  Brief    : Scoreboard bench for spi_reg_update_scheduler. Stimulus queues
//             expected active-register snapshots and commit pulses with the
//             cycle they must appear in; a monitor checks them as they occur.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_update_scheduler;

    localparam int NR = 5;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [6:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          period_start;
    logic          force_commit;
    logic          hold;
    logic [8*NR-1:0] regs_active;
    logic          pending;
    logic          commit_done;
    logic [7:0]    drop_count;

    spi_reg_update_scheduler #(
        .NUM_REGS       (NR),
        .FIFO_DEPTH     (4),
        .IMMEDIATE_MASK (5'b00011)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .period_start (period_start),
        .force_commit (force_commit),
        .hold         (hold),
        .regs_active  (regs_active),
        .pending      (pending),
        .commit_done  (commit_done),
        .drop_count   (drop_count)
    );

    typedef struct {
        logic [8*NR-1:0] val;
        int              cyc;
    } exp_t;

    exp_t            act_q[$];
    int              commit_q[$];
    logic [8*NR-1:0] exp_regs;
    logic [8*NR-1:0] prev_active;
    int              cyc;
    int              n_checks;
    int              n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Single write frame; if imm, queue the active-register change at +2.
    task automatic wr1(input logic [6:0] a, input logic [7:0] d, input bit imm);
        exp_t e;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        check("wr_ready_single", 64'(wr_ready), 64'd1);
        if (imm) begin
            exp_regs[8*a +: 8] = d;
            e.val = exp_regs;
            e.cyc = cyc + 2;
            act_q.push_back(e);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    // Boundary request pulse; if expect_commit, exp_regs must already hold the post-commit image.
    task automatic pulse(input bit use_force, input bit expect_commit);
        exp_t e;
        if (use_force) force_commit = 1'b1;
        else           period_start = 1'b1;
        if (expect_commit) begin
            e.val = exp_regs;
            e.cyc = cyc + 2;
            act_q.push_back(e);
            commit_q.push_back(cyc + 2);
        end
        tick();
        period_start = 1'b0;
        force_commit = 1'b0;
    endtask

    // Monitor: every change of regs_active and every commit_done pulse consumes a queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_active = regs_active;
        end else begin
            if (regs_active !== prev_active) begin
                if (act_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_active_change: got %0h expected %0h (cycle %0d)",
                             regs_active, prev_active, cyc);
                end else begin
                    exp_t e;
                    e = act_q.pop_front();
                    check("active_value", 64'(regs_active), 64'(e.val));
                    check("active_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_active = regs_active;
            if (commit_done === 1'b1) begin
                if (commit_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_commit_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    int c;
                    c = commit_q.pop_front();
                    check("commit_cycle", 64'(cyc), 64'(c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   guard;
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        exp_regs     = '0;
        rst          = 1'b1;
        wr_valid     = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        period_start = 1'b0;
        force_commit = 1'b0;
        hold         = 1'b0;

        // Reset state
        wait_cycles(3);
        check("rst_regs_active", 64'(regs_active), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_commit_done", 64'(commit_done), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        tick();

        // Deferred register: waits for period_start
        wr1(7'd4, 8'h80, 1'b0);
        wait_cycles(4);
        check("t1_pending_before", 64'(pending), 64'd1);
        check("t1_reg4_before", 64'(regs_active[39:32]), 64'h00);
        exp_regs[39:32] = 8'h80;
        pulse(1'b0, 1'b1);
        wait_cycles(4);
        check("t1_pending_after", 64'(pending), 64'd0);

        // Immediate register
        wr1(7'd0, 8'hA5, 1'b1);
        wait_cycles(4);
        check("t2_pending", 64'(pending), 64'd0);

        // Back-to-back burst to addr 2; one pop per cycle keeps ready high
        wr_valid = 1'b1;
        wr_addr  = 7'd2;
        for (int k = 1; k <= 6; k++) begin
            wr_data = 8'(k);
            guard = 0;
            while (!wr_ready && guard < 10) begin
                tick();
                guard++;
            end
            check("t3_burst_ready", 64'(wr_ready), 64'd1);
            tick();
        end
        wr_valid = 1'b0;
        wait_cycles(4);
        check("t3_pending", 64'(pending), 64'd1);
        exp_regs[23:16] = 8'h06;
        pulse(1'b0, 1'b1);
        wait_cycles(4);

        // Invalid addresses: dropped, counter saturates
        wr1(7'd7, 8'h33, 1'b0);
        check("t4_drop_one", 64'(drop_count), 64'd1);
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        for (int k = 0; k < 300; k++) begin
            wr_addr = 7'(5 + (k % 123));
            tick();
            if (k >= 252 && k <= 254) begin
                check("t4_drop_sat", 64'(drop_count), (k + 2 > 255) ? 64'd255 : 64'(k + 2));
            end
        end
        wr_valid = 1'b0;
        tick();
        check("t4_drop_final", 64'(drop_count), 64'd255);
        check("t4_pending", 64'(pending), 64'd0);

        // Hold suppresses boundary requests; force_commit after release
        hold = 1'b1;
        wr1(7'd3, 8'h44, 1'b0);
        wait_cycles(4);
        pulse(1'b0, 1'b0);
        wait_cycles(4);
        check("t5_reg3_held", 64'(regs_active[31:24]), 64'h00);
        check("t5_pending_held", 64'(pending), 64'd1);
        hold = 1'b0;
        tick();
        exp_regs[31:24] = 8'h44;
        pulse(1'b1, 1'b1);
        wait_cycles(4);
        check("t5_pending_after", 64'(pending), 64'd0);

        // Pop colliding with the commit cycle
        wr1(7'd4, 8'h20, 1'b0);
        wait_cycles(4);
        wr_valid = 1'b1;
        wr_addr  = 7'd4;
        wr_data  = 8'h10;
        exp_regs[39:32] = 8'h20;
        pulse(1'b0, 1'b1);
        wr_valid = 1'b0;
        tick();
        check("t6_pending_after_collision", 64'(pending), 64'd1);
        wait_cycles(3);
        exp_regs[39:32] = 8'h10;
        pulse(1'b0, 1'b1);
        wait_cycles(4);
        check("t6_pending_final", 64'(pending), 64'd0);

        check("active_queue_drained", 64'(act_q.size()), 64'd0);
        check("commit_queue_drained", 64'(commit_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_update_scheduler.md
Name: spi_reg_update_scheduler

Overview:
- Sits between the SPI write-frame decoder and the output/PWM configuration registers.
- Accepts decoded write frames (address, data) through a valid/ready handshake and buffers them in a small FIFO.
- Applies buffered frames to shadow registers, then commits the shadow registers to the active outputs only at PWM period boundaries. This prevents mid-period glitches on duty and enable values.
- Registers selected by IMMEDIATE_MASK bypass the boundary wait and update the active outputs directly.

Parameters:
NUM_REGS, 5, number of 8-bit configuration registers (addresses 0..NUM_REGS-1)
FIFO_DEPTH, 4, write-frame FIFO entries; power of 2, minimum 2
IMMEDIATE_MASK, 5'b00011, bit i=1: register i updates its active value on pop, with no boundary wait

Ports:
clk  input  1  system clock, the only clock
rst  input  1  synchronous, active-high reset
wr_valid  input  1  write frame valid
wr_addr  input  7  write frame register address
wr_data  input  8  write frame data
wr_ready  output  1  frame accepted when wr_valid && wr_ready
period_start  input  1  one-cycle pulse from the PWM counter at period wrap
force_commit  input  1  one-cycle request to commit without waiting for period_start
hold  input  1  1 = suppress commits; frames still buffer into the shadow registers
regs_active  output  8*NUM_REGS  active register values; register i occupies bits [8i+7:8i]
pending  output  1  1 when any shadow register is dirty
commit_done  output  1  one-cycle pulse in the cycle after a commit
drop_count  output  8  saturating count of frames with invalid addresses

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - regs_active, all shadow registers, all dirty bits: 0.
  - FIFO empty; state IDLE.
  - pending=0, commit_done=0, drop_count=0.
- Handshake and FIFO:
  - wr_ready = !fifo_full (combinational). During reset the FIFO is empty, so wr_ready=1.
  - Accept occurs when wr_valid && wr_ready.
  - An accepted frame with wr_addr >= NUM_REGS is not pushed. drop_count increments and saturates at 255.
  - Push and pop in the same cycle on a full FIFO is not permitted, because wr_ready=0 while full.
  - Push and pop in the same cycle at other occupancies keeps the count unchanged.
- Pop:
  - Whenever the FIFO is non-empty, one entry pops per cycle, in any state.
  - For a popped entry at address a: shadow[a] <= data.
  - If IMMEDIATE_MASK[a]=1, regs_active[a] <= data as well, and dirty[a] is unchanged.
  - Otherwise dirty[a] <= 1.
  - Latency: a frame pushed into an empty FIFO in cycle N is visible in shadow (and in active, for immediate registers) at N+2.
  - Repeated writes to the same address: last popped value wins.
- FSM states: IDLE, PENDING, COMMIT.
  - IDLE: no dirty bits set. Go to PENDING when any dirty bit becomes set. period_start and force_commit are ignored.
  - PENDING: if (period_start || force_commit) && !hold, go to COMMIT. Otherwise stay.
  - COMMIT (one cycle):
    - For every i with dirty[i]=1: regs_active[i] <= shadow[i], and dirty[i] is cleared.
    - commit_done=1 in the following cycle.
    - Next state is PENDING if a pop in this cycle set any dirty bit, else IDLE.
- Commit/pop collision: a pop landing in the COMMIT cycle is excluded from that commit.
  - Active takes the pre-pop shadow value; shadow takes the new data.
  - The dirty bit for the popped address ends set (the set wins over the clear).
- Commit latency: period_start asserted in cycle N while in PENDING makes regs_active change visibly at N+2, with commit_done high in cycle N+2.
- period_start and force_commit arriving while hold=1 are lost. No request is stored.
- pending = |dirty (combinational from registered dirty bits).
- Reset mid-operation: all FIFO contents, shadow values, and dirty bits are discarded. The next cycle is in the reset state.

Test Plan:
- Reset, then write addr 4 = 8'h80, no period_start -> regs_active[4] stays 0x00 and pending=1. Pulse period_start -> regs_active[4]=0x80 two cycles later, commit_done pulses once, pending=0.
- Write addr 0 = 8'hA5 (immediate) -> regs_active[0]=0xA5 two cycles after accept, pending stays 0, no commit_done.
- Hold wr_valid high with 6 back-to-back frames to addr 2, data 1..6 -> wr_ready drops only when the FIFO is full, all 6 accepted. After period_start, regs_active[2]=0x06.
- Write addr 7 = 0x33, then 300 more invalid-address frames -> no register changes, drop_count=255.
- hold=1, dirty addr 3 = 0x44, pulse period_start -> no change. Release hold, pulse force_commit -> regs_active[3]=0x44.
- Time the pop of addr 4 = 0x10 into the COMMIT cycle with prior shadow[4]=0x20 dirty -> regs_active[4]=0x20, pending=1. Next period_start -> 0x10.
